harris_corner_detector: RTL and testbench
=========================================

# harris_corner_detector

Streaming Harris corner detector for raster-order greyscale frames, one pixel per clock. It computes Sobel gradients and 3x3 box-summed structure-tensor terms, then evaluates the Harris response R = det − k·trace². For every accepted pixel it emits one `is_corner` flag after a fixed pipeline latency. It sits between the pixel source and downstream feature-selection logic.

## Interface
- `IMG_WIDTH`, 256: pixels per row (≥ 8).
- `IMG_HEIGHT`, 256: rows per frame (≥ 8).
- `PIXEL_W`, 8: unsigned pixel width.
- `GRAD_W`, 16: signed gradient width (must hold ±4·(2^PIXEL_W−1)).
- `RESP_W`, 32: signed response width after saturation.
- `K_W`, 8: width of the Harris k fraction.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pixel_in` in PIXEL_W: unsigned pixel, raster order.
- `valid_in` in 1: `pixel_in` is accepted on this edge.
- `threshold` in RESP_W: unsigned corner threshold, sampled live at the final stage.
- `k_param` in K_W: k = k_param / 2^K_W, sampled live at the final stage.
- `is_corner` out 1: corner flag for the reported centre pixel.
- `valid_out` out 1: `is_corner` is valid this cycle.

## Operation
- Column counter c and row counter r advance only on accepted pixels.
  - c wraps at IMG_WIDTH−1, then r increments.
  - r wraps at IMG_HEIGHT−1, so frames stream back to back with no gap required.
- Two raw line buffers plus shift registers form a 3x3 pixel window. Sobel, with pixels zero-extended to signed:
  - Ix = (p[−1,+1] + 2p[0,+1] + p[+1,+1]) − (p[−1,−1] + 2p[0,−1] + p[+1,−1])
  - Iy = (p[+1,−1] + 2p[+1,0] + p[+1,+1]) − (p[−1,−1] + 2p[−1,0] + p[−1,+1])
  - Both are full precision, sign-extended to GRAD_W.
- Products Ixx = Ix², Iyy = Iy², Ixy = Ix·Iy are exact, at 2·GRAD_W signed.
- Two product line buffers (three fields each) plus shift registers form a 3x3 window. Sxx, Syy, Sxy are exact 3x3 sums.
- Response, computed internally in 64-bit signed:
  - det = Sxx·Syy − Sxy²
  - tr = Sxx + Syy
  - R = det − ((k_param·tr²) >>> K_W)
  - R saturates to signed RESP_W.
- Reported centre for the pixel accepted at (r, c) is (r−2, c−2).
- `is_corner` = 1 only when all of the following hold:
  - r ≥ 4 and c ≥ 4 (the full window lies inside the frame);
  - R_sat > 0;
  - R_sat > threshold, compared as unsigned.
- Otherwise `is_corner` = 0.
- Line-buffer contents are never cleared. Border masking makes stale data irrelevant.

## Timing
- Pipeline is 4 registered stages, each carrying a valid bit:
  1. gradients;
  2. products;
  3. window sums;
  4. response, compare and output registers.
- A pixel accepted at edge t gives `valid_out` = 1 after edge t+4, for exactly one cycle per accepted pixel, in input order.
- When `valid_in` = 0, the bubble propagates: `valid_out` = 0 four cycles later. Counters, line buffers and windows do not advance.
- Results are independent of gap pattern.
- No backpressure exists; the consumer must always accept.
- Reset, asynchronous on `rst_n` low:
  - `valid_out` = 0, `is_corner` = 0;
  - all stage valid bits = 0;
  - r = c = 0.
- Reset mid-frame discards in-flight results. The next accepted pixel is (0, 0).
- `threshold` and `k_param` changes take effect on the stage-4 edge that uses them. No frame-boundary latching.

## Structure
- Shared package holds:
  - internal response width (64);
  - window sum width (2·GRAD_W + 4);
  - pipeline latency constant (4).
- One sub-module is natural: `line_buffer_3row`, parameterised by data width and IMG_WIDTH. It produces a 3-row column tap and is instantiated for raw pixels and for the packed {Ixx, Iyy, Ixy} products.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-stream -> `valid_out` = 0 and `is_corner` = 0 immediately. The first output after release maps to centre (−2, −2) and is 0.
- **Flat frame.** Flat 256x256 frame of value 128, threshold = 1000, k_param = 5 -> 65536 outputs, all `is_corner` = 0.
- **Square.** White square (255) on black at rows/cols 100..149, threshold = 1000, k_param = 5 -> `is_corner` = 1 within 1 pixel of centres (100,100), (100,149), (149,100), (149,149). It is 0 at edge midpoint (100,125) and at interior (125,125).
- **Straight edge.** Vertical step at column 128 -> R ≤ 0 along the edge, so all outputs are 0.
- **Gaps.** Square frame with `valid_in` deasserted every third cycle -> the sequence of `is_corner` values on `valid_out` cycles is identical to the gap-free run. Each `valid_out` occurs 4 edges after its pixel.
- **Border.** Bright 3x3 blob at rows/cols 0..2 -> all outputs with r < 4 or c < 4 are 0. Two back-to-back frames produce identical per-frame output.

Source files
------------

// File: rtl/harris_corner_detector_pkg.sv
// Shared widths and latency for the streaming Harris corner detector.
package harris_corner_detector_pkg;

  localparam int RESP_INT_W = 64;
  localparam int PIPE_LAT   = 4;

  function automatic int sum_width(input int grad_w);
    return 2 * grad_w + 4;
  endfunction

endpackage

// File: rtl/harris_corner_detector_line_buffer_3row.sv
// Two-row line store giving a vertical 3-tap column: row0 = current, row1 = one row up, row2 = two rows up.
module line_buffer_3row
  import harris_corner_detector_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IMG_WIDTH = 256,
  localparam int COL_W    = $clog2(IMG_WIDTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [COL_W-1:0]  i_col,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_row0,
  output logic [DATA_W-1:0] o_row1,
  output logic [DATA_W-1:0] o_row2
);

  logic [DATA_W-1:0] r_mem_a [IMG_WIDTH];
  logic [DATA_W-1:0] r_mem_b [IMG_WIDTH];

  // Contents are never cleared; border masking downstream hides stale rows.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem_a[i_col] <= i_data;
      r_mem_b[i_col] <= r_mem_a[i_col];
    end
  end

  assign o_row0 = i_data;
  assign o_row1 = r_mem_a[i_col];
  assign o_row2 = r_mem_b[i_col];

endmodule

// File: rtl/harris_corner_detector.sv
// Streaming Harris corner detector: input register, then gradients, products, window sums, response/compare.
// valid_in qualifies pixel_in on each edge; no backpressure; valid_out pulses once per accepted pixel.
module harris_corner_detector
  import harris_corner_detector_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int PIXEL_W    = 8,
  parameter int GRAD_W     = 16,
  parameter int RESP_W     = 32,
  parameter int K_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               valid_in,
  input  logic [RESP_W-1:0]  threshold,
  input  logic [K_W-1:0]     k_param,
  output logic               is_corner,
  output logic               valid_out
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int PROD_W = 2 * GRAD_W;
  localparam int SUM_W  = sum_width(GRAD_W);
  localparam logic signed [RESP_INT_W-1:0] RESP_MAX =
    (RESP_INT_W'(1) <<< (RESP_W - 1)) - RESP_INT_W'(1);
  localparam logic signed [RESP_INT_W-1:0] RESP_MIN = -(RESP_INT_W'(1) <<< (RESP_W - 1));

  logic [COL_W-1:0]         r_col, r_s0_col, r_s1_col, r_s2_col;
  logic [ROW_W-1:0]         r_row;
  logic [PIPE_LAT:0]        r_vld;
  logic [PIPE_LAT-1:0]      r_ok;
  logic                     r_is_corner;
  logic [PIXEL_W-1:0]       r_s0_pix;
  logic                     w_ok_in;

  assign w_ok_in = (r_row >= ROW_W'(4)) && (r_col >= COL_W'(4));

  // Valid and border flags shift every edge so bubbles propagate; only windows gate on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_vld       <= '0;
      r_ok        <= '0;
      r_is_corner <= 1'b0;
    end else begin
      r_vld       <= {r_vld[PIPE_LAT-1:0], valid_in};
      r_ok        <= {r_ok[PIPE_LAT-2:0], w_ok_in};
      r_is_corner <= r_vld[PIPE_LAT-1] && w_hit;
      if (valid_in) begin
        if (r_col == COL_W'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign is_corner = r_is_corner;
  assign valid_out = r_vld[PIPE_LAT];

  logic [PIXEL_W-1:0]     w_prow0, w_prow1, w_prow2;
  logic [3*PIXEL_W-1:0]   w_pcol, r_pcol1, r_pcol2;

  line_buffer_3row #(.DATA_W(PIXEL_W), .IMG_WIDTH(IMG_WIDTH)) u_pix_lb (
    .clk(clk), .i_en(r_vld[0]), .i_col(r_s0_col), .i_data(r_s0_pix),
    .o_row0(w_prow0), .o_row1(w_prow1), .o_row2(w_prow2)
  );

  assign w_pcol = {w_prow2, w_prow1, w_prow0};

  always_ff @(posedge clk) begin
    if (r_vld[0]) begin
      r_pcol1 <= w_pcol;
      r_pcol2 <= r_pcol1;
    end
  end

  // w_p[row][col]: row 0 = top (r-2), col 0 = left (c-2), col 2 = incoming column.
  logic signed [GRAD_W-1:0] w_p [3][3];
  logic signed [GRAD_W-1:0] w_ix, w_iy, r_ix, r_iy;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_p[i][0] = $signed(GRAD_W'(r_pcol2[(2-i)*PIXEL_W +: PIXEL_W]));
      w_p[i][1] = $signed(GRAD_W'(r_pcol1[(2-i)*PIXEL_W +: PIXEL_W]));
      w_p[i][2] = $signed(GRAD_W'(w_pcol[(2-i)*PIXEL_W +: PIXEL_W]));
    end
  end

  assign w_ix = (w_p[0][2] + w_p[1][2] + w_p[1][2] + w_p[2][2])
              - (w_p[0][0] + w_p[1][0] + w_p[1][0] + w_p[2][0]);
  assign w_iy = (w_p[2][0] + w_p[2][1] + w_p[2][1] + w_p[2][2])
              - (w_p[0][0] + w_p[0][1] + w_p[0][1] + w_p[0][2]);

  logic signed [PROD_W-1:0] r_xx, r_yy, r_xy;
  logic [3*PROD_W-1:0]      w_qrow0, w_qrow1, w_qrow2;
  logic signed [SUM_W-1:0]  w_csum [3];
  logic signed [SUM_W-1:0]  r_ccol1 [3];
  logic signed [SUM_W-1:0]  r_ccol2 [3];
  logic signed [SUM_W-1:0]  r_sxx, r_syy, r_sxy;

  line_buffer_3row #(.DATA_W(3*PROD_W), .IMG_WIDTH(IMG_WIDTH)) u_prod_lb (
    .clk(clk), .i_en(r_vld[2]), .i_col(r_s2_col), .i_data({r_xx, r_yy, r_xy}),
    .o_row0(w_qrow0), .o_row1(w_qrow1), .o_row2(w_qrow2)
  );

  // Field 0 = xx, 1 = yy, 2 = xy; each column is pre-summed vertically.
  always_comb begin
    for (int f = 0; f < 3; f++) begin
      w_csum[f] = SUM_W'($signed(w_qrow0[(2-f)*PROD_W +: PROD_W]))
                + SUM_W'($signed(w_qrow1[(2-f)*PROD_W +: PROD_W]))
                + SUM_W'($signed(w_qrow2[(2-f)*PROD_W +: PROD_W]));
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld[2]) begin
      r_ccol1 <= w_csum;
      r_ccol2 <= r_ccol1;
    end
  end

  always_ff @(posedge clk) begin
    r_s0_pix <= pixel_in;
    r_s0_col <= r_col;
    r_ix     <= w_ix;
    r_iy     <= w_iy;
    r_s1_col <= r_s0_col;
    r_xx     <= PROD_W'(r_ix) * PROD_W'(r_ix);
    r_yy     <= PROD_W'(r_iy) * PROD_W'(r_iy);
    r_xy     <= PROD_W'(r_ix) * PROD_W'(r_iy);
    r_s2_col <= r_s1_col;
    r_sxx    <= w_csum[0] + r_ccol1[0] + r_ccol2[0];
    r_syy    <= w_csum[1] + r_ccol1[1] + r_ccol2[1];
    r_sxy    <= w_csum[2] + r_ccol1[2] + r_ccol2[2];
  end

  logic signed [RESP_INT_W-1:0] w_sxx, w_syy, w_sxy, w_det, w_tr, w_ktr2, w_resp;
  logic signed [RESP_W-1:0]     w_rsat;
  logic                         w_hit;

  assign w_sxx  = RESP_INT_W'(r_sxx);
  assign w_syy  = RESP_INT_W'(r_syy);
  assign w_sxy  = RESP_INT_W'(r_sxy);
  assign w_det  = w_sxx * w_syy - w_sxy * w_sxy;
  assign w_tr   = w_sxx + w_syy;
  assign w_ktr2 = ($signed(RESP_INT_W'(k_param)) * (w_tr * w_tr)) >>> K_W;
  assign w_resp = w_det - w_ktr2;

  always_comb begin
    if (w_resp > RESP_MAX)      w_rsat = RESP_W'(RESP_MAX);
    else if (w_resp < RESP_MIN) w_rsat = RESP_W'(RESP_MIN);
    else                        w_rsat = RESP_W'(w_resp);
  end

  assign w_hit = r_ok[PIPE_LAT-1] && !w_rsat[RESP_W-1] && (w_rsat != '0)
              && ($unsigned(w_rsat) > threshold);

endmodule

// File: tb/tb_harris_corner_detector.sv
// Bench for harris_corner_detector on a 16x16 frame against a frame-based Harris reference model.
module tb_harris_corner_detector;
  import harris_corner_detector_pkg::*;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int PW = 8;
  localparam int RW = 32;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          valid_in = 1'b0;
  logic [RW-1:0] threshold = '0;
  logic [KW-1:0] k_param = '0;
  logic          is_corner;
  logic          valid_out;

  harris_corner_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .threshold(threshold), .k_param(k_param), .is_corner(is_corner), .valid_out(valid_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  int   stamp_q[$];
  logic obs_q[$];
  logic ref_q[$];
  int   img[H][W];

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: Harris flag for the pixel accepted at (r, c), centre (r-2, c-2).
  function automatic logic model_corner(input int r, input int c);
    longint sxx, syy, sxy, ix, iy, det, tr, rr;
    int y, x;
    if (r < 4 || c < 4) return 1'b0;
    sxx = 0; syy = 0; sxy = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        y = r - 2 + dy;
        x = c - 2 + dx;
        ix = longint'(img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1]
                    - img[y-1][x-1] - 2*img[y][x-1] - img[y+1][x-1]);
        iy = longint'(img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1]
                    - img[y-1][x-1] - 2*img[y-1][x] - img[y-1][x+1]);
        sxx += ix * ix;
        syy += iy * iy;
        sxy += ix * iy;
      end
    end
    det = sxx * syy - sxy * sxy;
    tr  = sxx + syy;
    rr  = det - ((longint'(k_param) * tr * tr) >>> KW);
    if (rr > 64'sd2147483647) rr = 64'sd2147483647;
    else if (rr < -64'sd2147483648) rr = -64'sd2147483648;
    return (rr > 0) && (rr > longint'({32'd0, threshold}));
  endfunction

  // ---------------- monitor ----------------
  logic mon_e;
  int   mon_s;
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = stamp_q.pop_front();
        chk("is_corner", is_corner, mon_e);
        chk("latency", cyc - mon_s, 4);
        obs_q.push_back(is_corner);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input int r, input int c);
    @(negedge clk);
    pixel_in = PW'(img[r][c]);
    valid_in = 1'b1;
    exp_q.push_back(model_corner(r, c));
    stamp_q.push_back(cyc + 1);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    valid_in = 1'b0;
    pixel_in = PW'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input bit gaps);
    int n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && n > 0 && (n % 2) == 0) drive_idle();
        drive_pixel(r, c);
        n++;
      end
    end
  endtask

  task automatic drain();
    drive_idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic fill_flat(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = v;
  endtask

  task automatic fill_square(input int lo, input int hi);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (y >= lo && y <= hi && x >= lo && x <= hi) ? 255 : 0;
  endtask

  function automatic int count_ones(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi && i < obs_q.size(); i++) n += int'(obs_q[i]);
    return n;
  endfunction

  function automatic int obs_at(input int y, input int x);
    int idx = (y + 2) * W + (x + 2);
    return (idx < obs_q.size()) ? int'(obs_q[idx]) : -1;
  endfunction

  function automatic int near_corner(input int y, input int x);
    int any = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (obs_at(y + dy, x + dx) == 1) any = 1;
    return any;
  endfunction

  function automatic int seq_diff_ref();
    int d = 0;
    if (obs_q.size() != ref_q.size()) return -1;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== ref_q[i]) d++;
    return d;
  endfunction

  // ---------------- directed sequence ----------------
  int border_n;
  int repeat_d;

  initial begin
    threshold = 32'd1000;
    k_param   = 8'd5;

    #12;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_is_corner", is_corner, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_flat(128);
    obs_q.delete();
    send_frame(0);
    drain();
    chk("flat_count", obs_q.size(), W * H);
    chk("flat_corners", count_ones(0, W * H), 0);

    fill_square(5, 10);
    obs_q.delete();
    send_frame(0);
    drain();
    ref_q = obs_q;
    chk("sq_corner_tl", near_corner(5, 5), 1);
    chk("sq_corner_tr", near_corner(5, 10), 1);
    chk("sq_corner_bl", near_corner(10, 5), 1);
    chk("sq_corner_br", near_corner(10, 10), 1);
    chk("sq_edge_mid", obs_at(5, 7), 0);
    chk("sq_interior", obs_at(7, 7), 0);

    obs_q.delete();
    send_frame(1);
    drain();
    chk("gap_count", obs_q.size(), W * H);
    chk("gap_seq_diff", seq_diff_ref(), 0);

    threshold = 32'hFFFF_FFFF;
    obs_q.delete();
    send_frame(0);
    drain();
    chk("thr_max_corners", count_ones(0, W * H), 0);
    threshold = 32'd1000;

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x >= 8) ? 255 : 0;
    obs_q.delete();
    send_frame(0);
    drain();
    chk("edge_corners", count_ones(0, W * H), 0);

    fill_flat(0);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) img[y][x] = 255;
    obs_q.delete();
    send_frame(0);
    send_frame(0);
    drain();
    chk("border_count", obs_q.size(), 2 * W * H);
    border_n = 0;
    repeat_d = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if ((r < 4 || c < 4) && obs_q.size() == 2 * W * H)
            border_n += int'(obs_q[f * W * H + r * W + c]);
    for (int i = 0; i < W * H && obs_q.size() == 2 * W * H; i++)
      if (obs_q[i] !== obs_q[W * H + i]) repeat_d++;
    chk("border_mask", border_n, 0);
    chk("border_repeat", repeat_d, 0);

    fill_flat(128);
    for (int i = 0; i < 40; i++) drive_pixel(i / W, i % W);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", valid_out, 1);
    #1;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_is_corner", is_corner, 0);
    exp_q.delete();
    stamp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fill_square(5, 10);
    obs_q.delete();
    send_frame(0);
    drain();
    chk("post_reset_first", (obs_q.size() > 0) ? int'(obs_q[0]) : -1, 0);
    chk("post_reset_seq_diff", seq_diff_ref(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
